// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential
// binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Smallest digit count d with 10^d > 2^width - 1.
  function automatic int min_digits(input int width);
    longint maxv;
    longint pw;
    int     d;
    maxv = (longint'(1) << width) - 1;
    pw   = 10;
    d    = 1;
    for (int i = 0; i < 8; i++) begin
      if (pw <= maxv) begin
        d  = d + 1;
        pw = pw * 10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One BCD digit correction step of the
// shift-and-add-3 algorithm.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] nib,
  output logic [BCD_DIGIT_W-1:0] adj
);

  // Digits 5..9 would exceed 9 after the shift, so pre-add 3.
  always_comb begin
    adj = nib;
    if (nib >= BCD_DIGIT_W'(ADD3_THRESH)) begin
      adj = nib + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per
// clock, result held stable between conversions.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3,
  parameter int AUTO   = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          RST,
  input  logic [WIDTH-1:0]              bin_in,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = BW + WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be 1..16");
  end

  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_t          state;
  state_t          state_n;
  logic [WIDTH-1:0] bin_shift;
  logic [WIDTH-1:0] last_bin;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    scratch_adj;
  logic [SW-1:0]    shifted;
  logic [CW-1:0]    cnt;
  logic             trigger;
  logic             load;
  logic             step;
  logic             finish;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted = {scratch_adj, bin_shift} << 1;

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and datapath control.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    trigger = start ||
              ((AUTO != 0) && (bin_in != last_bin));
    unique case (1'b1)
      (state == IDLE): begin
        if (trigger) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      (state == SHIFT): begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  // Shift register, BCD scratch and iteration count.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      bin_shift <= '0;
      last_bin  <= '0;
      scratch   <= '0;
      cnt       <= '0;
    end else if (load) begin
      bin_shift <= bin_in;
      last_bin  <= bin_in;
      scratch   <= '0;
      cnt       <= '0;
    end else if (step) begin
      bin_shift <= shifted[WIDTH-1:0];
      scratch   <= shifted[SW-1:WIDTH];
      cnt       <= cnt + CW'(1);
    end
  end

  // Registered outputs; bcd_out moves only on the last iteration.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      busy <= (state_n == SHIFT);
      done <= finish;
      if (finish) begin
        bcd_out <= shifted[SW-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq,
// one manual-start and one auto-retrigger instance.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic [8:0]  m_bin;
  logic        m_start;
  logic        m_busy;
  logic        m_done;
  logic [11:0] m_bcd;
  logic [8:0]  a_bin;
  logic        a_start;
  logic        a_busy;
  logic        a_done;
  logic [11:0] a_bcd;

  int total = 0;
  int bad   = 0;
  int last_auto = 0;

  bin_to_bcd_seq #(.WIDTH(9), .DIGITS(3), .AUTO(0)) u_man (
    .CLOCK_50 (clk),
    .RST      (rst),
    .bin_in   (m_bin),
    .start    (m_start),
    .busy     (m_busy),
    .done     (m_done),
    .bcd_out  (m_bcd)
  );

  bin_to_bcd_seq #(.WIDTH(9), .DIGITS(3), .AUTO(1)) u_auto (
    .CLOCK_50 (clk),
    .RST      (rst),
    .bin_in   (a_bin),
    .start    (a_start),
    .busy     (a_busy),
    .done     (a_done),
    .bcd_out  (a_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = 0;
    x = v;
    for (int d = 0; d < 3; d++) begin
      r = r | (32'(x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic conv_man(input int v, input bit timing);
    m_bin   = 9'(v);
    m_start = 1'b1;
    tick;
    m_start = 1'b0;
    if (timing) check("m_busy_k", 32'(m_busy), 1);
    for (int i = 1; i <= 9; i++) begin
      tick;
      if (timing && i < 9) begin
        check("m_busy_run", 32'(m_busy), 1);
        check("m_done_run", 32'(m_done), 0);
      end
    end
    check("m_done_k9", 32'(m_done), 1);
    check("m_busy_k9", 32'(m_busy), 0);
    check("m_bcd", 32'(m_bcd), to_bcd(v));
  endtask

  task automatic auto_step(input int v);
    int  ndone;
    int  at;
    bit  conv;
    conv  = (v != last_auto);
    a_bin = 9'(v);
    ndone = 0;
    at    = 0;
    for (int i = 1; i <= 15; i++) begin
      tick;
      if (a_done) begin
        ndone++;
        if (at == 0) at = i;
      end
    end
    check("a_ndone", 32'(ndone), conv ? 1 : 0);
    if (conv) check("a_latency", 32'(at), 10);
    check("a_bcd", 32'(a_bcd), to_bcd(v));
    last_auto = v;
  endtask

  initial begin
    int v;
    int nd;
    int at;

    rst     = 1'b1;
    m_bin   = '0;
    m_start = 1'b0;
    a_bin   = '0;
    a_start = 1'b0;
    repeat (3) tick;
    check("rst_m_busy", 32'(m_busy), 0);
    check("rst_m_done", 32'(m_done), 0);
    check("rst_m_bcd", 32'(m_bcd), 0);
    check("rst_a_bcd", 32'(a_bcd), 0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (m_done || a_done || m_busy || a_busy) nd++;
    end
    check("idle_no_activity", 32'(nd), 0);
    check("idle_m_bcd", 32'(m_bcd), 0);

    conv_man(511, 1'b1);
    for (int k = 0; k < 512; k++) begin
      conv_man(k, k < 3);
    end
    for (int k = 0; k < 100; k++) begin
      conv_man(int'($urandom_range(0, 511)), 1'b0);
    end

    v = int'($urandom_range(0, 511));
    m_bin   = 9'(v);
    m_start = 1'b1;
    tick;
    m_start = 1'b0;
    repeat (3) tick;
    m_start = 1'b1;
    m_bin   = ~9'(v);
    tick;
    m_start = 1'b0;
    nd = 0;
    at = 0;
    for (int i = 5; i <= 20; i++) begin
      tick;
      if (m_done) begin
        nd++;
        if (at == 0) at = i;
      end
    end
    check("ign_ndone", 32'(nd), 1);
    check("ign_at", 32'(at), 9);
    check("ign_bcd", 32'(m_bcd), to_bcd(v));

    auto_step(42);
    auto_step(42);
    auto_step(7);

    a_bin = 9'd300;
    tick;
    repeat (5) tick;
    check("mid_busy", 32'(a_busy), 1);
    check("mid_hold", 32'(a_bcd), 32'h007);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(a_busy), 0);
    check("arst_bcd", 32'(a_bcd), 0);
    check("arst_done", 32'(a_done), 0);
    check("arst_m_bcd", 32'(m_bcd), 0);
    tick;
    tick;
    rst = 1'b0;
    nd = 0;
    at = 0;
    for (int i = 1; i <= 15; i++) begin
      tick;
      if (a_done) begin
        nd++;
        if (at == 0) at = i;
      end
    end
    check("rel_ndone", 32'(nd), 1);
    check("rel_at", 32'(at), 10);
    check("rel_bcd", 32'(a_bcd), 32'h300);
    last_auto = 300;

    v = 123;
    a_bin = 9'(v);
    at = 0;
    for (int i = 1; i <= 20 && at == 0; i++) begin
      tick;
      if (a_done) at = i;
    end
    check("dc_first", 32'(at), 10);
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    check("dc_accept", 32'(a_busy), 1);
    repeat (9) tick;
    check("dc_done", 32'(a_done), 1);
    check("dc_bcd", 32'(a_bcd), to_bcd(v));
    tick;
    last_auto = v;

    for (int k = 0; k < 30; k++) begin
      v = int'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) v = last_auto;
      auto_step(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
